// File: rtl/tpu_buffer_swap_ctrl_pkg.sv
// Shared types and constants for the TPU ping-pong buffer swap sequencer.
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWAP,
        DONE
    } sync_state_t;

    localparam int unsigned MASK_UB  = 0;
    localparam int unsigned MASK_ACC = 1;
    localparam int unsigned MASK_WT  = 2;
    localparam int unsigned MASK_W   = 3;
    localparam int unsigned BUSY_W   = 4;

    // Flip every selector whose mask bit is set; all bits commit together.
    function automatic logic [MASK_W-1:0] toggle_sel(input logic [MASK_W-1:0] sel,
                                                     input logic [MASK_W-1:0] mask);
        return sel ^ mask;
    endfunction

endpackage

// File: rtl/tpu_buffer_swap_ctrl_if.sv
// SYNC handshake, engine busy flags and buffer-select outputs of the swap sequencer.
interface tpu_buffer_swap_ctrl_if
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic              sync_req;
    logic [MASK_W-1:0] sync_mask;
    logic              sync_ready;
    logic              sys_busy;
    logic              vpu_busy;
    logic              dma_busy;
    logic              wt_busy;
    logic              ub_buf_sel;
    logic              acc_buf_sel;
    logic              wt_buf_sel;
    logic              sync_done;
    logic [CNT_W-1:0]  swap_count;
    logic              drain_timeout;

    modport master (
        output sync_req, sync_mask, sys_busy, vpu_busy, dma_busy, wt_busy,
        input  sync_ready, ub_buf_sel, acc_buf_sel, wt_buf_sel,
               sync_done, swap_count, drain_timeout
    );

    modport slave (
        input  sync_req, sync_mask, sys_busy, vpu_busy, dma_busy, wt_busy,
        output sync_ready, ub_buf_sel, acc_buf_sel, wt_buf_sel,
               sync_done, swap_count, drain_timeout
    );

endinterface

// File: rtl/tpu_buffer_swap_ctrl_quiet.sv
// tpu_quiet_detector: flags quiet_met once all engines have been idle for QUIET_CYCLES consecutive enabled cycles.
module tpu_quiet_detector #(
    parameter int unsigned QUIET_CYCLES = 2,
    parameter int unsigned BUSY_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [BUSY_W-1:0] busy,
    output logic              quiet_met
);
    localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

    logic [QW-1:0] cnt_q, cnt_d;
    logic          quiet_met_q, quiet_met_d;

    // Any busy engine, or leaving the counting window, restarts the run from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || (|busy)) begin
            cnt_d = '0;
        end else if (cnt_q != QW'(QUIET_CYCLES)) begin
            cnt_d = cnt_q + QW'(1);
        end
        quiet_met_d = (cnt_d == QW'(QUIET_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            quiet_met_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            quiet_met_q <= quiet_met_d;
        end
    end

    assign quiet_met = quiet_met_q;

endmodule

// File: rtl/tpu_buffer_swap_ctrl.sv
// Barrier/swap sequencer owning the UB/ACC/WT ping-pong selectors.
// Optional drain abort enabled by defining SYNC_TIMEOUT_EN.
module tpu_buffer_swap_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES  = 2,
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input logic                   clk,
    input logic                   rst,
    tpu_buffer_swap_ctrl_if.slave bus
);

    if (QUIET_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_cfg_check
        $error("tpu_buffer_swap_ctrl: QUIET_CYCLES and DRAIN_TIMEOUT must be >= 1");
    end

    sync_state_t       state_q, state_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [MASK_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sync_done_q, sync_done_d;
    logic              sync_ready_q, sync_ready_d;
    logic              accept;
    logic              quiet_met;
    logic [BUSY_W-1:0] busy_vec;

`ifdef SYNC_TIMEOUT_EN
    localparam int unsigned DCW = $clog2(DRAIN_TIMEOUT + 1);
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    assign accept   = bus.sync_req & sync_ready_q;
    assign busy_vec = {bus.wt_busy, bus.dma_busy, bus.vpu_busy, bus.sys_busy};

    tpu_quiet_detector #(
        .QUIET_CYCLES (QUIET_CYCLES),
        .BUSY_W       (BUSY_W)
    ) u_quiet (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == DRAIN),
        .clr       (accept),
        .busy      (busy_vec),
        .quiet_met (quiet_met)
    );

    // Next-state and registered-output logic; selectors only move on the DRAIN->SWAP edge.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        count_d = count_q;
`ifdef SYNC_TIMEOUT_EN
        drain_cnt_d = drain_cnt_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mask_d  = bus.sync_mask;
                    state_d = DRAIN;
`ifdef SYNC_TIMEOUT_EN
                    drain_cnt_d = '0;
`endif
                end
            end
            DRAIN: begin
                if (quiet_met) begin
                    state_d = SWAP;
                    sel_d   = toggle_sel(sel_q, mask_q);
                    count_d = count_q + CNT_W'(1);
                end
`ifdef SYNC_TIMEOUT_EN
                else if (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
`endif
            end
            SWAP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sync_ready_d = (state_d == IDLE);
        sync_done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            sel_q        <= '0;
            count_q      <= '0;
            sync_done_q  <= 1'b0;
            sync_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            sel_q        <= sel_d;
            count_q      <= count_d;
            sync_done_q  <= sync_done_d;
            sync_ready_q <= sync_ready_d;
        end
    end

`ifdef SYNC_TIMEOUT_EN
    // Sticky abort flag survives later successful swaps; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.drain_timeout = timeout_q;
`else
    assign bus.drain_timeout = 1'b0;
`endif

    assign bus.sync_ready  = sync_ready_q;
    assign bus.sync_done   = sync_done_q;
    assign bus.swap_count  = count_q;
    assign bus.ub_buf_sel  = sel_q[MASK_UB];
    assign bus.acc_buf_sel = sel_q[MASK_ACC];
    assign bus.wt_buf_sel  = sel_q[MASK_WT];

endmodule

// File: tb/tb_tpu_buffer_swap_ctrl.sv
// Directed bench for tpu_buffer_swap_ctrl: per-cycle vector table plus reset and drain-timeout sequences.
module tb_tpu_buffer_swap_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned NV    = 47;

    typedef struct {
        logic        req;
        logic [2:0]  mask;
        logic [3:0]  busy;   // {wt, dma, vpu, sys}
        logic [2:0]  sel;    // {wt, acc, ub}
        logic        done;
        logic        rdy;
        int unsigned cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t tbl [NV];

    tpu_buffer_swap_ctrl_if #(.CNT_W(CNT_W)) bus ();

    tpu_buffer_swap_ctrl #(
        .QUIET_CYCLES  (2),
        .DRAIN_TIMEOUT (16),
        .CNT_W         (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic req, input logic [2:0] mask, input logic [3:0] busy);
        bus.sync_req  = req;
        bus.sync_mask = mask;
        bus.sys_busy  = busy[0];
        bus.vpu_busy  = busy[1];
        bus.dma_busy  = busy[2];
        bus.wt_busy   = busy[3];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] sel, input logic done,
                           input logic rdy, input int unsigned cnt, input logic to);
        chk({tag, ".sel"}, 32'({bus.wt_buf_sel, bus.acc_buf_sel, bus.ub_buf_sel}), 32'(sel));
        chk({tag, ".done"}, 32'(bus.sync_done), 32'(done));
        chk({tag, ".ready"}, 32'(bus.sync_ready), 32'(rdy));
        chk({tag, ".count"}, 32'(bus.swap_count), cnt);
        chk({tag, ".timeout"}, 32'(bus.drain_timeout), 32'(to));
    endtask

    function automatic vec_t v(input logic req, input logic [2:0] mask, input logic [3:0] busy,
                               input logic [2:0] sel, input logic done, input logic rdy,
                               input int unsigned cnt);
        vec_t r;
        r.req = req; r.mask = mask; r.busy = busy;
        r.sel = sel; r.done = done; r.rdy = rdy; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // Full barrier, single-bank swap, held request, pure barrier, long busy, busy glitch.
        tbl[0]  = v(1, 3'b111, 4'h0, 3'b000, 0, 0, 0);
        tbl[1]  = v(0, 3'b000, 4'h0, 3'b000, 0, 0, 0);
        tbl[2]  = v(0, 3'b000, 4'h0, 3'b000, 0, 0, 0);
        tbl[3]  = v(0, 3'b000, 4'h0, 3'b111, 0, 0, 1);
        tbl[4]  = v(0, 3'b000, 4'h0, 3'b111, 1, 0, 1);
        tbl[5]  = v(0, 3'b000, 4'h0, 3'b111, 0, 1, 1);
        tbl[6]  = v(1, 3'b010, 4'h0, 3'b111, 0, 0, 1);
        tbl[7]  = v(0, 3'b000, 4'h0, 3'b111, 0, 0, 1);
        tbl[8]  = v(0, 3'b000, 4'h0, 3'b111, 0, 0, 1);
        tbl[9]  = v(0, 3'b000, 4'h0, 3'b101, 0, 0, 2);
        tbl[10] = v(0, 3'b000, 4'h0, 3'b101, 1, 0, 2);
        tbl[11] = v(0, 3'b000, 4'h0, 3'b101, 0, 1, 2);
        tbl[12] = v(1, 3'b001, 4'h0, 3'b101, 0, 0, 2);
        tbl[13] = v(1, 3'b001, 4'h0, 3'b101, 0, 0, 2);
        tbl[14] = v(1, 3'b001, 4'h0, 3'b101, 0, 0, 2);
        tbl[15] = v(1, 3'b001, 4'h0, 3'b100, 0, 0, 3);
        tbl[16] = v(1, 3'b001, 4'h0, 3'b100, 1, 0, 3);
        tbl[17] = v(1, 3'b001, 4'h0, 3'b100, 0, 1, 3);
        tbl[18] = v(1, 3'b000, 4'h0, 3'b100, 0, 0, 3);
        tbl[19] = v(0, 3'b000, 4'h0, 3'b100, 0, 0, 3);
        tbl[20] = v(0, 3'b000, 4'h0, 3'b100, 0, 0, 3);
        tbl[21] = v(0, 3'b000, 4'h0, 3'b100, 0, 0, 4);
        tbl[22] = v(0, 3'b000, 4'h0, 3'b100, 1, 0, 4);
        tbl[23] = v(0, 3'b000, 4'h0, 3'b100, 0, 1, 4);
        tbl[24] = v(1, 3'b111, 4'h1, 3'b100, 0, 0, 4);
        for (int i = 25; i <= 33; i++) tbl[i] = v(0, 3'b000, 4'h1, 3'b100, 0, 0, 4);
        tbl[34] = v(0, 3'b000, 4'h0, 3'b100, 0, 0, 4);
        tbl[35] = v(0, 3'b000, 4'h0, 3'b100, 0, 0, 4);
        tbl[36] = v(0, 3'b000, 4'h0, 3'b011, 0, 0, 5);
        tbl[37] = v(0, 3'b000, 4'h0, 3'b011, 1, 0, 5);
        tbl[38] = v(0, 3'b000, 4'h0, 3'b011, 0, 1, 5);
        tbl[39] = v(1, 3'b111, 4'h0, 3'b011, 0, 0, 5);
        tbl[40] = v(0, 3'b000, 4'h0, 3'b011, 0, 0, 5);
        tbl[41] = v(0, 3'b000, 4'h2, 3'b011, 0, 0, 5);
        tbl[42] = v(0, 3'b000, 4'h0, 3'b011, 0, 0, 5);
        tbl[43] = v(0, 3'b000, 4'h0, 3'b011, 0, 0, 5);
        tbl[44] = v(0, 3'b000, 4'h0, 3'b100, 0, 0, 6);
        tbl[45] = v(0, 3'b000, 4'h0, 3'b100, 1, 0, 6);
        tbl[46] = v(0, 3'b000, 4'hF, 3'b100, 0, 1, 6);

        rst = 1'b1;
        set_in(0, 3'b000, 4'h0);
        tick();
        tick();
        chk_all("reset", 3'b000, 0, 1, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_in(tbl[i].req, tbl[i].mask, tbl[i].busy);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].sel, tbl[i].done, tbl[i].rdy, tbl[i].cnt, 0);
        end

        // Reset during DRAIN aborts the pending swap and clears all state.
        set_in(1, 3'b111, 4'h4);
        tick();
        set_in(0, 3'b000, 4'h4);
        for (int i = 0; i < 3; i++) tick();
        chk_all("drain_pre_rst", 3'b100, 0, 0, 6, 0);
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 3'b000, 0, 1, 0, 0);
        rst = 1'b0;
        set_in(0, 3'b000, 4'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("post_rst%0d", i), 3'b000, 0, 1, 0, 0);
        end

`ifdef SYNC_TIMEOUT_EN
        // Stuck DMA: abort on the 16th DRAIN cycle, selectors untouched, flag sticky.
        set_in(1, 3'b111, 4'h4);
        tick();
        set_in(0, 3'b000, 4'h4);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk_all($sformatf("to_wait%0d", k), 3'b000, 0, 0, 0, 0);
        end
        tick();
        chk_all("to_fire", 3'b000, 0, 1, 0, 1);
        set_in(0, 3'b000, 4'h0);
        for (int i = 0; i < 3; i++) tick();
        chk_all("to_sticky", 3'b000, 0, 1, 0, 1);
        set_in(1, 3'b001, 4'h0);
        tick();
        set_in(0, 3'b000, 4'h0);
        for (int i = 0; i < 3; i++) tick();
        chk_all("to_swap", 3'b001, 0, 0, 1, 1);
        tick();
        chk_all("to_done", 3'b001, 1, 0, 1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("to_rst", 3'b000, 0, 1, 0, 0);
`else
        // Without the abort feature DRAIN waits indefinitely, then swaps once quiet.
        set_in(1, 3'b111, 4'h4);
        tick();
        set_in(0, 3'b000, 4'h4);
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk_all($sformatf("stuck%0d", k), 3'b000, 0, 0, 0, 0);
        end
        set_in(0, 3'b000, 4'h0);
        tick();
        tick();
        chk_all("stuck_quiet", 3'b000, 0, 0, 0, 0);
        tick();
        chk_all("stuck_swap", 3'b111, 0, 0, 1, 0);
        tick();
        chk_all("stuck_done", 3'b111, 1, 0, 1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
